// File: rtl/pmem_burst_responder_pkg.sv
// Shared types and geometry for the physical-memory burst responder.
package pmem_pkg;

    localparam int unsigned BEATS    = 4;
    localparam int unsigned BEAT_W   = 64;
    localparam int unsigned LINE_W   = 256;
    localparam int unsigned OFFSET_W = 5;
    // Wide enough for LATENCY (0..255) plus up to 7 jitter cycles.
    localparam int unsigned WAIT_W   = 9;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } pmem_state_t;

    typedef logic [BEAT_W-1:0] pmem_beat_t;

    function automatic pmem_beat_t line_beat(input logic [LINE_W-1:0] line,
                                             input logic [1:0]        beat);
        return line[BEAT_W*beat +: BEAT_W];
    endfunction

endpackage

// File: rtl/pmem_burst_responder_lfsr.sv
// 3-bit Galois LFSR (x^3 + x^2 + 1), seeded to 3'b101, stepping once per enable.
module pmem_lfsr (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [2:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= 3'b101;
        end else if (en) begin
            value <= {1'b0, value[2:1]} ^ (value[0] ? 3'b110 : 3'b000);
        end
    end

endmodule

// File: rtl/pmem_burst_responder.sv
// Line-granular memory answering 256-bit line requests as four 64-bit beats after a
// programmable latency; define PMEM_JITTER_EN to add 0..7 LFSR-driven extra wait cycles.
module pmem_burst_responder
    import pmem_pkg::*;
#(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  logic [63:0] pmem_wdata,
    output logic        pmem_resp,
    output logic [63:0] pmem_rdata
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef logic [IDX_W-1:0] idx_t;

    pmem_state_t       state, state_next;
    logic              op_write, op_write_next;
    idx_t              index, index_next;
    logic [1:0]        beat, beat_next;
    logic [WAIT_W-1:0] cnt, cnt_next;
    logic [WAIT_W-1:0] wait_len, wait_len_next;
    logic [WAIT_W-1:0] accept_wait;
    logic              resp_next;
    logic              load_rdata;
    logic              mem_we;
    logic              accept;
    logic              op_held;
    idx_t              rd_index;
    logic [1:0]        rd_beat;
    pmem_beat_t        rd_beat_data;
    logic [2:0]        jitter;
    logic              unused_addr_bits;

    logic [LINE_W-1:0] mem [DEPTH];

    assign unused_addr_bits = ^pmem_address;

    assign accept  = (state == IDLE) && (pmem_read ^ pmem_write);
    assign op_held = op_write ? pmem_write : pmem_read;

`ifdef PMEM_JITTER_EN
    pmem_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .value (jitter)
    );
`else
    assign jitter = '0;
`endif

    assign accept_wait  = WAIT_W'(LATENCY) + WAIT_W'(jitter);
    assign rd_beat_data = line_beat(mem[rd_index], rd_beat);

    // Outputs are registered, so the transition into BURST already loads beat 0;
    // each BURST cycle retires the beat on the bus and loads the following one.
    always_comb begin
        state_next    = state;
        op_write_next = op_write;
        index_next    = index;
        beat_next     = beat;
        cnt_next      = cnt;
        wait_len_next = wait_len;
        resp_next     = 1'b0;
        load_rdata    = 1'b0;
        mem_we        = 1'b0;
        rd_index      = index;
        rd_beat       = beat;

        case (state)
            IDLE: begin
                if (accept) begin
                    op_write_next = pmem_write;
                    index_next    = pmem_address[OFFSET_W +: IDX_W];
                    wait_len_next = accept_wait;
                    cnt_next      = '0;
                    beat_next     = '0;
                    if (accept_wait == '0) begin
                        state_next = BURST;
                        resp_next  = 1'b1;
                        load_rdata = 1'b1;
                        rd_index   = index_next;
                        rd_beat    = '0;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end

            WAIT: begin
                if (!op_held) begin
                    state_next = IDLE;
                end else if (cnt == wait_len - WAIT_W'(1)) begin
                    state_next = BURST;
                    resp_next  = 1'b1;
                    load_rdata = 1'b1;
                    rd_beat    = '0;
                end else begin
                    cnt_next = cnt + WAIT_W'(1);
                end
            end

            BURST: begin
                if (!op_held) begin
                    state_next = IDLE;
                end else begin
                    mem_we = op_write;
                    if (beat == 2'(BEATS - 1)) begin
                        state_next = DONE;
                    end else begin
                        beat_next  = beat + 2'd1;
                        resp_next  = 1'b1;
                        load_rdata = 1'b1;
                        rd_beat    = beat + 2'd1;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_write   <= 1'b0;
            index      <= '0;
            beat       <= '0;
            cnt        <= '0;
            wait_len   <= '0;
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
        end else begin
            state     <= state_next;
            op_write  <= op_write_next;
            index     <= index_next;
            beat      <= beat_next;
            cnt       <= cnt_next;
            wait_len  <= wait_len_next;
            pmem_resp <= resp_next;
            if (load_rdata) begin
                pmem_rdata <= rd_beat_data;
            end
        end
    end

    // Backing store is deliberately not reset; writes already committed survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[index][BEAT_W*beat +: BEAT_W] <= pmem_wdata;
        end
    end

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Self-checking bench: time-based transaction model plus directed literal expectations.
module tb_pmem_burst_responder;

    localparam int L     = 10;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pmem_read = 1'b0;
    logic        pmem_write = 1'b0;
    logic [31:0] pmem_address = '0;
    logic [63:0] pmem_wdata = '0;
    logic        pmem_resp;
    logic [63:0] pmem_rdata;

    int checks = 0;
    int failures = 0;
    bit run = 1'b0;

    pmem_burst_responder #(.LATENCY(L), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each accepted request owns a timeline measured in edges since accept.
    logic [63:0] mm [int];
    int          cyc = 0;
    int          t0 = 0;
    int          next_ok = 0;
    bit          busy = 1'b0;
    bit          m_write = 1'b0;
    int          m_idx = 0;
    logic        exp_resp = 1'b0;
    logic [63:0] exp_rdata = '0;

    function automatic logic [63:0] mm_get(input int key);
        if (mm.exists(key)) return mm[key];
        return 'x;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      = 1'b0;
            exp_resp  = 1'b0;
            exp_rdata = '0;
            next_ok   = 0;
        end else begin
            int k;
            cyc++;
            if (busy) begin
                k = cyc - t0;
                if (!(m_write ? pmem_write : pmem_read)) begin
                    busy     = 1'b0;
                    exp_resp = 1'b0;
                    next_ok  = cyc + 1;
                end else begin
                    if (m_write && k >= L + 1) mm[m_idx*4 + (k - L - 1)] = pmem_wdata;
                    if (k == L + 4) begin
                        busy     = 1'b0;
                        exp_resp = 1'b0;
                        next_ok  = cyc + 2;
                    end else begin
                        exp_resp = (k >= L);
                        if (k >= L) exp_rdata = mm_get(m_idx*4 + (k - L));
                    end
                end
            end else if (cyc >= next_ok && (pmem_read ^ pmem_write)) begin
                busy     = 1'b1;
                t0       = cyc;
                m_write  = pmem_write;
                m_idx    = int'((pmem_address >> 5) % DEPTH);
                exp_resp = (L == 0);
                if (L == 0) exp_rdata = mm_get(m_idx*4);
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            check("model_resp", {255'b0, pmem_resp}, {255'b0, exp_resp});
            if (exp_resp && !m_write) check("model_rdata", {192'b0, pmem_rdata}, {192'b0, exp_rdata});
        end
    end

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [255:0] wline,
                        input int both, input int stop_after, input bit do_rst,
                        output int first_k, output int nbeats, output logic [255:0] rline);
        first_k = -1;
        nbeats  = 0;
        rline   = '0;
        @(posedge clk); #2;
        pmem_address = addr;
        if (both > 0) begin
            pmem_read  = 1'b1;
            pmem_write = 1'b1;
            repeat (both) @(posedge clk);
            #2;
        end
        pmem_read  = !wr;
        pmem_write = wr;
        @(posedge clk);
        for (int k = 0; k < 200 && nbeats < stop_after; k++) begin
            @(negedge clk);
            if (pmem_resp) begin
                if (first_k < 0) first_k = k;
                pmem_wdata = wline[64*nbeats +: 64];
                rline[64*nbeats +: 64] = pmem_rdata;
                nbeats++;
            end
        end
        check("beat_count", nbeats, stop_after);
        if (do_rst) begin
            #1 rst = 1'b1;
            #1;
            check("rst_resp", {255'b0, pmem_resp}, '0);
            check("rst_rdata", {192'b0, pmem_rdata}, '0);
            @(posedge clk); #2;
            rst        = 1'b0;
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
        end else begin
            @(posedge clk); #2;
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
            if (stop_after < 4) begin
                @(negedge clk);
                @(negedge clk);
                check("abort_resp", {255'b0, pmem_resp}, '0);
            end
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l1, l2, l3, got, mixed;
        int fk, nb, cnt_resp;
        logic [31:0] resp_mask;

        l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        l2 = {64'h8888_0000_8888_0004, 64'h7777_0000_7777_0003,
              64'h6666_0000_6666_0002, 64'h5555_0000_5555_0001};
        l3 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        mixed = {l2[255:128], l3[127:0]};

        repeat (3) @(posedge clk);
        run = 1'b1;
        #2;
        check("reset_resp", {255'b0, pmem_resp}, '0);
        check("reset_rdata", {192'b0, pmem_rdata}, '0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        xfer(1'b1, 32'h0000_0040, l1, 0, 4, 1'b0, fk, nb, got);
        check("write_first_resp", fk, 10);

        xfer(1'b0, 32'h0000_0040, '0, 0, 4, 1'b0, fk, nb, got);
        check("read_first_resp", fk, 10);
        check("read_line", got, l1);

        xfer(1'b0, 32'h0000_005F, '0, 0, 4, 1'b0, fk, nb, got);
        check("offset_ignored", got, l1);

        xfer(1'b1, 32'h0000_8040, l2, 0, 4, 1'b0, fk, nb, got);
        xfer(1'b0, 32'h0000_0040, '0, 0, 4, 1'b0, fk, nb, got);
        check("alias_line", got, l2);

        xfer(1'b0, 32'h0000_0040, '0, 3, 4, 1'b0, fk, nb, got);
        check("both_then_read_first", fk, 10);
        check("both_then_read_line", got, l2);

        xfer(1'b1, 32'h0000_0040, l3, 0, 2, 1'b0, fk, nb, got);
        xfer(1'b0, 32'h0000_0040, '0, 0, 4, 1'b0, fk, nb, got);
        check("abort_partial_line", got, mixed);

        xfer(1'b0, 32'h0000_0040, '0, 0, 2, 1'b1, fk, nb, got);
        xfer(1'b0, 32'h0000_0040, '0, 0, 4, 1'b0, fk, nb, got);
        check("post_rst_first", fk, 10);
        check("post_rst_line", got, mixed);

        // Read held continuously: second accept lands 16 edges after the first.
        @(posedge clk); #2;
        pmem_address = 32'h0000_0040;
        pmem_read    = 1'b1;
        @(posedge clk);
        cnt_resp  = 0;
        resp_mask = '0;
        for (int k = 0; k < 31; k++) begin
            @(negedge clk);
            if (pmem_resp) begin
                cnt_resp++;
                resp_mask[k] = 1'b1;
            end
        end
        @(posedge clk); #2;
        pmem_read = 1'b0;
        check("b2b_resp_count", cnt_resp, 8);
        check("b2b_resp_pattern", {224'b0, resp_mask}, {224'b0, 32'h3C00_3C00});
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
